hazard_stall_unit: RTL and testbench
====================================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset, with ports clock and reset_n.
REQ-002 clock  input  1  rising-edge pipeline clock, shared with the ID/EX instruction buffer.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 id_instr  input  32  instruction currently in ID (IF/ID register output).
REQ-005 ex_instr  input  32  instruction currently in EX (ID/EX instruction buffer output).
REQ-006 ex_valid  input  1  1 = ex_instr is a real instruction; 0 = bubble.
REQ-007 pc_write  output  1  1 = PC may advance.
REQ-008 if_id_write  output  1  1 = IF/ID register may load.
REQ-009 id_ex_flush  output  1  1 = ID/EX buffer loads NOP (0x00000000) instead of the ID instruction.
REQ-010 held_instr  output  32  ID instruction captured on stall entry, for debug/replay.
REQ-011 stall_active  output  1  1 in every stalled cycle.
REQ-012 stall_cycles  output  16  saturating count of stalled cycles (see Configuration).

Function
REQ-013 Decode SHALL use opcode [31:26], rs [25:21], rt [20:16], rd [15:11].
REQ-014 EX destination: LW (100011) and ADDI/SLTI/ANDI/ORI (001000/001010/001100/001101) -> rt; R-type (000000) -> rd; all other opcodes -> none.
REQ-015 ID sources: rs for all opcodes except J/JAL (000010/000011) and all-zero NOP; rt in addition for R-type, BEQ (000100), BNE (000101) and SW (101011).
REQ-016 A destination of register 0 SHALL never cause a hazard, and ex_valid=0 SHALL suppress all detection.
REQ-017 Load-use hazard: EX is LW and its destination matches any ID source.
REQ-018 Branch hazard: ID is BEQ/BNE and any EX destination (load or ALU) matches a branch source.
REQ-019 FSM states SHALL be RUN and HOLD only.
REQ-020 In RUN with a hazard, the same cycle SHALL drive pc_write=0, if_id_write=0, id_ex_flush=1 and stall_active=1 (combinational, zero latency).
REQ-021 In RUN, a branch hazard whose EX source is LW SHALL transition to HOLD; every other hazard SHALL stay in RUN, giving a 1-cycle stall.
REQ-022 In HOLD the outputs SHALL be identical to REQ-020, hazard inputs SHALL be ignored, and the next state SHALL be RUN unconditionally, giving a 2-cycle stall.
REQ-023 In RUN without a hazard: pc_write=1, if_id_write=1, id_ex_flush=0, stall_active=0.
REQ-024 held_instr SHALL load id_instr on the rising edge ending the first stall cycle of each stall, and hold its value otherwise.
REQ-025 Back-to-back hazards (a new hazard detected in RUN the cycle after HOLD) SHALL start a new stall with no gap cycle.

Reset
REQ-026 While reset_n=0: state=RUN, held_instr=0, stall_cycles=0, pc_write=1, if_id_write=1, id_ex_flush=0, stall_active=0, regardless of inputs.
REQ-027 Reset asserted during HOLD SHALL abort the stall immediately; the first edge after release SHALL evaluate from RUN.

Configuration
REQ-028 Macro HAZARD_STALL_CNT_EN: when defined, stall_cycles SHALL increment by 1 on each rising edge where stall_active=1 and saturate at 0xFFFF.
REQ-029 When HAZARD_STALL_CNT_EN is not defined, stall_cycles SHALL be tied to 0 and no counter flops SHALL exist; all other behaviour is unchanged.

Verification
REQ-030 LW $2,0($1) in EX, ADD $3,$2,$4 in ID -> exactly 1 cycle with pc_write=0 and id_ex_flush=1; held_instr=0x00441820.
REQ-031 LW $2 in EX, BEQ $2,$5 in ID -> 2 consecutive stall cycles (RUN->HOLD->RUN); with ex_valid=0 in the second cycle, outputs are still stalled.
REQ-032 ADD $2,$1,$1 in EX, BEQ $2,$0 in ID -> 1 stall cycle; ADD $0 or LW $0 in EX -> no stall.
REQ-033 LW $2 in EX, SW $2 in ID, ex_valid=0 -> no stall; the same with ex_valid=1 -> 1 stall cycle; J in ID with LW $31 in EX -> no stall.
REQ-034 Assert reset_n=0 mid-HOLD -> outputs return to the reset values of REQ-026 asynchronously, and the next post-reset cycle carries no residual stall.
REQ-035 With HAZARD_STALL_CNT_EN defined, force 70000 stall cycles -> stall_cycles=0xFFFF; with it undefined, stall_cycles=0 throughout.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use / branch hazard detector with RUN/HOLD stall FSM
//
// Purpose: watches the instruction in ID and the instruction in EX and stalls the
// front end (PC and IF/ID hold, ID/EX takes a bubble) whenever ID would read a
// register that EX has not produced in time. Load-use stalls one cycle; a branch
// in ID that depends on an ALU result stalls one cycle; a branch that depends on a
// load stalls two cycles (RUN -> HOLD -> RUN).
//
// Ports:
//   clock        in   rising-edge pipeline clock
//   reset_n      in   asynchronous active-low reset
//   id_instr     in   [31:0] instruction in ID
//   ex_instr     in   [31:0] instruction in EX
//   ex_valid     in   1 = ex_instr is real, 0 = bubble
//   pc_write     out  1 = PC may advance
//   if_id_write  out  1 = IF/ID may load
//   id_ex_flush  out  1 = ID/EX loads NOP
//   held_instr   out  [31:0] ID instruction captured at the end of each stall's first cycle
//   stall_active out  1 in every stalled cycle
//   stall_cycles out  [15:0] saturating stalled-cycle count
//
// Build option: HAZARD_STALL_CNT_EN enables the stall_cycles counter; when it is
// undefined stall_cycles is constant zero and no counter flops exist.

module hazard_stall_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] id_instr,
    input  logic [31:0] ex_instr,
    input  logic        ex_valid,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_flush,
    output logic [31:0] held_instr,
    output logic        stall_active,
    output logic [15:0] stall_cycles
);

    localparam logic S_RUN  = 1'b0;
    localparam logic S_HOLD = 1'b1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic        r_state;
    logic [31:0] r_held_instr;

    logic [5:0]  w_ex_op;
    logic [4:0]  w_ex_rt;
    logic [4:0]  w_ex_rd;
    logic [5:0]  w_id_op;
    logic [4:0]  w_id_rs;
    logic [4:0]  w_id_rt;
    logic        w_ex_is_lw;
    logic        w_ex_is_alui;
    logic        w_ex_is_rtype;
    logic [4:0]  w_ex_dest;
    logic        w_ex_dest_ok;
    logic        w_id_is_nop;
    logic        w_id_is_branch;
    logic        w_id_use_rs;
    logic        w_id_use_rt;
    logic        w_src_match;
    logic        w_load_use;
    logic        w_branch_haz;
    logic        w_hazard;
    logic        w_stall;
    logic        w_unused_bits;

    assign w_ex_op = ex_instr[31:26];
    assign w_ex_rt = ex_instr[20:16];
    assign w_ex_rd = ex_instr[15:11];
    assign w_id_op = id_instr[31:26];
    assign w_id_rs = id_instr[25:21];
    assign w_id_rt = id_instr[20:16];

    // EX rs and immediate/funct fields play no part in destination decode.
    assign w_unused_bits = ^{ex_instr[25:21], ex_instr[10:0]};

    always_comb begin
        w_ex_is_lw     = (w_ex_op == OP_LW);
        w_ex_is_alui   = (w_ex_op == OP_ADDI) || (w_ex_op == OP_SLTI) ||
                         (w_ex_op == OP_ANDI) || (w_ex_op == OP_ORI);
        w_ex_is_rtype  = (w_ex_op == OP_RTYPE);
        w_ex_dest      = w_ex_is_rtype ? w_ex_rd : w_ex_rt;
        // $0 is never a real destination, and a bubble in EX produces nothing.
        w_ex_dest_ok   = ex_valid && (w_ex_is_lw || w_ex_is_alui || w_ex_is_rtype) &&
                         (w_ex_dest != 5'd0);

        // The all-zero word is the NOP and reads nothing, even though it decodes as R-type.
        w_id_is_nop    = (id_instr == 32'h0000_0000);
        w_id_is_branch = (w_id_op == OP_BEQ) || (w_id_op == OP_BNE);
        w_id_use_rs    = !w_id_is_nop && (w_id_op != OP_J) && (w_id_op != OP_JAL);
        w_id_use_rt    = !w_id_is_nop && ((w_id_op == OP_RTYPE) || w_id_is_branch ||
                                          (w_id_op == OP_SW));
        w_src_match    = (w_id_use_rs && (w_id_rs == w_ex_dest)) ||
                         (w_id_use_rt && (w_id_rt == w_ex_dest));

        w_load_use     = w_ex_dest_ok && w_ex_is_lw && w_src_match;
        w_branch_haz   = w_ex_dest_ok && w_id_is_branch && w_src_match;

        // Gating with reset_n forces idle outputs while reset is held, whatever the inputs.
        w_hazard       = reset_n && (w_load_use || w_branch_haz);
        w_stall        = reset_n && ((r_state == S_HOLD) || w_hazard);
    end

    assign pc_write     = !w_stall;
    assign if_id_write  = !w_stall;
    assign id_ex_flush  = w_stall;
    assign stall_active = w_stall;
    assign held_instr   = r_held_instr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_RUN;
            r_held_instr <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_hazard) begin
                        r_held_instr <= id_instr;
                        // A branch waiting on a load needs the load data a further cycle.
                        if (w_branch_haz && w_ex_is_lw) begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= 16'd0;
        end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit

module tb_hazard_stall_unit;

    localparam logic [31:0] I_NOP      = 32'h0000_0000;
    localparam logic [31:0] I_LW2      = 32'h8C22_0000; // LW   $2,0($1)
    localparam logic [31:0] I_LW0      = 32'h8C20_0000; // LW   $0,0($1)
    localparam logic [31:0] I_LW31     = 32'h8C3F_0000; // LW   $31,0($1)
    localparam logic [31:0] I_ADD_324  = 32'h0044_1820; // ADD  $3,$2,$4
    localparam logic [31:0] I_ADD_300  = 32'h0000_1820; // ADD  $3,$0,$0
    localparam logic [31:0] I_ADD_211  = 32'h0021_1020; // ADD  $2,$1,$1
    localparam logic [31:0] I_ADD_011  = 32'h0021_0020; // ADD  $0,$1,$1
    localparam logic [31:0] I_ADDI2    = 32'h2022_0005; // ADDI $2,$1,5
    localparam logic [31:0] I_BEQ25    = 32'h1045_0000; // BEQ  $2,$5
    localparam logic [31:0] I_BEQ20    = 32'h1040_0000; // BEQ  $2,$0
    localparam logic [31:0] I_BEQ00    = 32'h1000_0000; // BEQ  $0,$0
    localparam logic [31:0] I_SW2      = 32'hAC62_0000; // SW   $2,0($3)
    localparam logic [31:0] I_J31      = 32'h0BE0_0000; // J with rs-field bits = 31

    typedef struct {
        string       name;
        logic        stall;
        logic [31:0] held;
        logic [15:0] cnt;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [31:0] id_instr;
    logic [31:0] ex_instr;
    logic        ex_valid;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_flush;
    logic [31:0] held_instr;
    logic        stall_active;
    logic [15:0] stall_cycles;

    exp_t        sb_q[$];
    int          checks;
    int          errors;
    logic [15:0] exp_cnt;

    hazard_stall_unit dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .id_instr    (id_instr),
        .ex_instr    (ex_instr),
        .ex_valid    (ex_valid),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .id_ex_flush (id_ex_flush),
        .held_instr  (held_instr),
        .stall_active(stall_active),
        .stall_cycles(stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] cnt_of(input logic [15:0] c);
`ifdef HAZARD_STALL_CNT_EN
        return c;
`else
        return 16'd0;
`endif
    endfunction

    // Monitor: every negedge with a pending expectation compares the DUT outputs.
    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [3:0] got_ctl;
            logic [3:0] exp_ctl;
            e = sb_q.pop_front();
            got_ctl = {pc_write, if_id_write, id_ex_flush, stall_active};
            exp_ctl = {!e.stall, !e.stall, e.stall, e.stall};
            checks = checks + 1;
            if (got_ctl !== exp_ctl || held_instr !== e.held || stall_cycles !== e.cnt) begin
                errors = errors + 1;
                $display("FAIL %s: got ctl=%b held=%h cnt=%h, expected ctl=%b held=%h cnt=%h",
                         e.name, got_ctl, held_instr, stall_cycles, exp_ctl, e.held, e.cnt);
            end
        end
    end

    function automatic void expect_now(input string name, input logic stall,
                                       input logic [31:0] held);
        exp_t e;
        e.name  = name;
        e.stall = stall;
        e.held  = held;
        e.cnt   = cnt_of(exp_cnt);
        sb_q.push_back(e);
    endfunction

    // Drive one cycle of inputs just after the rising edge and queue its expectation.
    task automatic drive(input string name, input logic [31:0] id, input logic [31:0] ex,
                         input logic v, input logic stall, input logic [31:0] held);
        @(posedge clock);
        #1;
        id_instr = id;
        ex_instr = ex;
        ex_valid = v;
        expect_now(name, stall, held);
        if (stall && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        exp_cnt  = 16'd0;
        reset_n  = 1'b0;
        id_instr = I_BEQ25;
        ex_instr = I_LW2;
        ex_valid = 1'b1;
        // Reset state checked with hazardous inputs present.
        expect_now("reset_state", 1'b0, 32'h0);
        @(negedge clock);
        #1;
        id_instr = I_NOP;
        ex_instr = I_NOP;
        ex_valid = 1'b0;
        reset_n  = 1'b1;

        drive("idle",            I_NOP,     I_NOP,     1'b0, 1'b0, 32'h0);
        drive("lu_add_stall",    I_ADD_324, I_LW2,     1'b1, 1'b1, 32'h0);
        drive("lu_add_release",  I_ADD_324, I_NOP,     1'b0, 1'b0, 32'h0044_1820);
        drive("lw_beq_cyc1",     I_BEQ25,   I_LW2,     1'b1, 1'b1, 32'h0044_1820);
        drive("lw_beq_cyc2",     I_BEQ25,   I_LW2,     1'b0, 1'b1, 32'h1045_0000);
        drive("lw_beq_release",  I_BEQ25,   I_NOP,     1'b0, 1'b0, 32'h1045_0000);
        drive("add_beq_stall",   I_BEQ20,   I_ADD_211, 1'b1, 1'b1, 32'h1045_0000);
        drive("add_beq_release", I_BEQ20,   I_NOP,     1'b0, 1'b0, 32'h1040_0000);
        drive("add_r0_nostall",  I_BEQ00,   I_ADD_011, 1'b1, 1'b0, 32'h1040_0000);
        drive("lw_r0_nostall",   I_ADD_300, I_LW0,     1'b1, 1'b0, 32'h1040_0000);
        drive("sw_exv0_nostall", I_SW2,     I_LW2,     1'b0, 1'b0, 32'h1040_0000);
        drive("sw_lu_stall",     I_SW2,     I_LW2,     1'b1, 1'b1, 32'h1040_0000);
        drive("j_lw31_nostall",  I_J31,     I_LW31,    1'b1, 1'b0, 32'hAC62_0000);
        drive("addi_add_nostall",I_ADD_324, I_ADDI2,   1'b1, 1'b0, 32'hAC62_0000);
        drive("nop_id_nostall",  I_NOP,     I_LW2,     1'b1, 1'b0, 32'hAC62_0000);
        // Back-to-back: HOLD followed immediately by a new load-use stall.
        drive("b2b_run",         I_BEQ25,   I_LW2,     1'b1, 1'b1, 32'hAC62_0000);
        drive("b2b_hold",        I_BEQ25,   I_ADD_211, 1'b1, 1'b1, 32'h1045_0000);
        drive("b2b_new_stall",   I_ADD_324, I_LW2,     1'b1, 1'b1, 32'h1045_0000);
        drive("b2b_release",     I_ADD_324, I_NOP,     1'b0, 1'b0, 32'h0044_1820);

        // Reset asserted while in HOLD, inputs still hazardous.
        drive("pre_hold",        I_BEQ25,   I_LW2,     1'b1, 1'b1, 32'h0044_1820);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        exp_cnt = 16'd0;
        #1;
        expect_now("reset_mid_hold", 1'b0, 32'h0);
        @(negedge clock);
        #1;
        id_instr = I_ADD_324;
        ex_instr = I_NOP;
        ex_valid = 1'b0;
        reset_n  = 1'b1;
        drive("post_reset_run",  I_ADD_324, I_NOP,     1'b0, 1'b0, 32'h0);

        // Long continuous load-use stall for the counter.
        @(posedge clock);
        #1;
        id_instr = I_ADD_324;
        ex_instr = I_LW2;
        ex_valid = 1'b1;
`ifdef HAZARD_STALL_CNT_EN
        for (int i = 0; i < 70000; i++) begin
`else
        for (int i = 0; i < 300; i++) begin
`endif
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            @(posedge clock);
        end
        #1;
        expect_now("cnt_long_stall", 1'b1, 32'h0044_1820);

        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(posedge clock);
        if (sb_q.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
